qam_tx_frame_ctrl: RTL and testbench

- Frame sequencer for the QAM transmitter front end.
- Drives the 1-bit-to-2-bit serial-to-parallel converter (SPC) through its `en`/`Din` inputs:
  - first a fixed preamble, then `frame_len` payload bits pulled from a bit source with a valid/ready handshake, then a zero pad bit if the total bit count is odd.
- Mirrors the SPC pair phase internally and presents each completed 2-bit symbol to the mapper with a valid/ready handshake.
- Blocks the SPC while a symbol is still unaccepted, so an unaccepted symbol is never overwritten.

---
 rtl/qam_tx_frame_ctrl_pkg.sv | 23 ++
 rtl/qam_tx_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_qam_tx_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_tx_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// qam_tx_pkg : shared state encoding and default frame constants
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qam_tx_pkg;

  localparam int DEF_LEN_W = 12;
  localparam int DEF_PRE_BITS = 16;
  localparam logic [15:0] DEF_PRE_PAT = 16'hA5F0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_PAY   = 3'd2,
    S_PAD   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/qam_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// qam_tx_frame_ctrl : preamble/payload/pad sequencer feeding a 1-to-2 bit SPC
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qam_tx_frame_ctrl
  import qam_tx_pkg::*;
#(
  parameter int                  LEN_W    = DEF_LEN_W,
  parameter int                  PRE_BITS = DEF_PRE_BITS,
  parameter logic [PRE_BITS-1:0] PRE_PAT  = DEF_PRE_PAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             spc_en,
  output logic             spc_din,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PRE_BITS);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PRE_BITS - 1);

  state_t             state;
  state_t             state_nxt;
  logic               phase;
  logic               inflight_ph;
  logic [IDX_W-1:0]   pre_idx;
  logic [LEN_W-1:0]   pay_cnt;
  logic [LEN_W-1:0]   len_q;
  logic               may_issue;
  logic               issue;
  logic               issue_bit;

  // A second bit may never land while the previous pair is still unaccepted,
  // nor while a pair-completing bit is still travelling into the SPC.
  assign may_issue = phase | ((~sym_valid | sym_ready) & ~(spc_en & inflight_ph));
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_bit = 1'b0;
    done      = 1'b0;
    bit_ready = (state == S_PAY) & may_issue & (pay_cnt < len_q);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_PRE;
      end
      S_PRE: begin
        issue     = may_issue;
        issue_bit = PRE_PAT[pre_idx];
        if (issue && (pre_idx == '0))
          state_nxt = (len_q == '0) ? S_DRAIN : S_PAY;
      end
      S_PAY: begin
        issue     = bit_valid & bit_ready;
        issue_bit = bit_in;
        // Last payload bit landing in phase 0 leaves an odd total: pad it.
        if (issue && ((pay_cnt + LEN_W'(1)) == len_q))
          state_nxt = phase ? S_DRAIN : S_PAD;
      end
      S_PAD: begin
        issue     = may_issue;
        issue_bit = 1'b0;
        if (issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!sym_valid && !spc_en) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      inflight_ph <= 1'b0;
      pre_idx     <= '0;
      pay_cnt     <= '0;
      len_q       <= '0;
      spc_en      <= 1'b0;
      spc_din     <= 1'b0;
      sym_valid   <= 1'b0;
    end else begin
      state   <= state_nxt;
      spc_en  <= issue;
      spc_din <= issue & issue_bit;
      if (issue) begin
        inflight_ph <= phase;
        phase       <= ~phase;
      end
      if (spc_en && inflight_ph)
        sym_valid <= 1'b1;
      else if (sym_valid && sym_ready)
        sym_valid <= 1'b0;
      if (state == S_IDLE && start) begin
        len_q   <= frame_len;
        pre_idx <= IDX_TOP;
        pay_cnt <= '0;
      end
      if (state == S_PRE && issue && pre_idx != '0)
        pre_idx <= pre_idx - IDX_W'(1);
      if (state == S_PAY && issue)
        pay_cnt <= pay_cnt + LEN_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qam_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qam_tx_frame_ctrl : directed bench for the frame controller plus an SPC
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_qam_tx_frame_ctrl;

  localparam int LEN_W = 12;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic             spc_en;
  logic             spc_din;
  logic             sym_valid;
  logic             sym_ready;
  logic             busy;
  logic             done;

  logic       spc_ph;
  logic       spc_first;
  logic [1:0] spc_out;

  int         checks;
  int         errors;
  int         done_cnt;
  int         xf;
  logic [1:0] sym_q[$];
  logic [1:0] exp_q[$];

  qam_tx_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .spc_en    (spc_en),
    .spc_din   (spc_din),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit-to-2-bit serial-to-parallel converter sharing the controller reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spc_ph    <= 1'b0;
      spc_first <= 1'b0;
      spc_out   <= 2'b00;
    end else if (spc_en) begin
      if (!spc_ph) spc_first <= spc_din;
      else         spc_out   <= {spc_first, spc_din};
      spc_ph <= ~spc_ph;
    end
  end

  always @(negedge clk) begin
    if (sym_valid && sym_ready) sym_q.push_back(spc_out);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_test();
    @(posedge clk); #1;
    sym_q.delete();
    done_cnt = 0;
  endtask

  task automatic check_syms(input string tag);
    check({tag, "_count"}, 32'(sym_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, 32'((i < sym_q.size()) ? sym_q[i] : 2'b00), 32'(exp_q[i]));
  endtask

  // Waits for done after the frame is already running; then checks the
  // cycle after done has busy and done both low.
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  // vpat gives bit_valid per cycle, counted from the first bit_ready cycle.
  task automatic run_frame(input int len, input logic [15:0] bits,
                           input logic [3:0] vpat, input int budget,
                           output int xfers);
    int k;
    int src;
    bit armed;
    bit seen;
    xfers = 0; src = 0; k = 0; armed = 1'b0; seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    bit_valid = (len > 0) && vpat[0];
    bit_in = bits[0];
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bit_valid && bit_ready) begin
        xfers++;
        src++;
      end
      if (bit_ready) armed = 1'b1;
      if (done) seen = 1'b1;
      if (armed) k++;
      @(posedge clk); #1;
      bit_valid = (src < len) && vpat[k % 4];
      bit_in = bits[src % 16];
    end
    bit_valid = 1'b0;
    check("frame_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    bit got;
    checks = 0; errors = 0; done_cnt = 0;
    rst = 1'b0; start = 1'b0; frame_len = '0;
    bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b1;

    // Reset, then idle
    repeat (3) @(negedge clk);
    check("rst_spc_en", 32'(spc_en), 32'd0);
    check("rst_spc_din", 32'(spc_din), 32'd0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_spc_en", 32'(spc_en), 32'd0);
    end

    // Preamble only
    new_test();
    run_frame(0, 16'h0000, 4'hF, 200, xf);
    exp_q = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
    check_syms("pre_only_sym");
    check("pre_only_done_cnt", 32'(done_cnt), 32'd1);
    check("pre_only_xfers", 32'(xf), 32'd0);

    // Odd payload 1,1,0 followed by a pad zero
    new_test();
    run_frame(3, 16'b011, 4'hF, 200, xf);
    exp_q = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00};
    check_syms("odd_sym");
    check("odd_done_cnt", 32'(done_cnt), 32'd1);
    check("odd_xfers", 32'(xf), 32'd3);

    // Source bubbles: valid 1,0,0,1 with payload 0 then 1
    new_test();
    run_frame(2, 16'b10, 4'b1001, 200, xf);
    exp_q = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01};
    check_syms("bubble_sym");
    check("bubble_xfers", 32'(xf), 32'd2);

    // Backpressure on the first symbol
    new_test();
    sym_ready = 1'b0;
    start = 1'b1;
    frame_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (sym_valid) got = 1'b1;
    end
    check("bp_sym_valid_seen", 32'(got), 32'd1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_out_stable", 32'(spc_out), 32'(2'b10));
      check("bp_spc_en", 32'(spc_en), 32'd0);
      check("bp_bit_ready", 32'(bit_ready), 32'd0);
      check("bp_sym_valid", 32'(sym_valid), 32'd1);
    end
    @(posedge clk); #1;
    sym_ready = 1'b1;
    @(negedge clk);
    check("bp_release_same_cycle", 32'(spc_en), 32'd0);
    @(negedge clk);
    check("bp_resume_next_cycle", 32'(spc_en), 32'd1);
    wait_done(200);
    exp_q = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
    check_syms("bp_sym");

    // Abort mid-payload, then a clean restart
    new_test();
    start = 1'b1;
    frame_len = LEN_W'(8);
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (bit_ready) got = 1'b1;
    end
    check("abort_pay_reached", 32'(got), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sym_valid", 32'(sym_valid), 32'd0);
    check("abort_spc_en", 32'(spc_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bit_valid = 1'b0;
    new_test();
    run_frame(0, 16'h0000, 4'hF, 200, xf);
    exp_q = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
    check_syms("restart_sym");
    check("restart_done_cnt", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
